// File: rtl/cpu_multicycle.sv
// Multi-cycle CPU with a 16-bit instruction word, a 16-entry register file (r0 reads zero)
// and req/ack instruction/data memory ports that tolerate any number of wait states.
module cpu_multicycle #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned PC_W    = 8,
    parameter int unsigned DADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [15:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [PC_W-1:0]    pc,
    output logic               retire,
    output logic               halted
);

    localparam logic [3:0] OpAdd  = 4'h0;
    localparam logic [3:0] OpSub  = 4'h1;
    localparam logic [3:0] OpAnd  = 4'h2;
    localparam logic [3:0] OpOr   = 4'h3;
    localparam logic [3:0] OpSlt  = 4'h4;
    localparam logic [3:0] OpAddi = 4'h5;
    localparam logic [3:0] OpLw   = 4'h6;
    localparam logic [3:0] OpSw   = 4'h7;
    localparam logic [3:0] OpBeq  = 4'h8;
    localparam logic [3:0] OpJmp  = 4'h9;
    localparam logic [3:0] OpHalt = 4'hF;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_t;

    state_t            state;
    logic [15:0]       ir;
    logic [DATA_W-1:0] regs [16];
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] op_d;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] imm_z;
    logic [3:0]        opcode;
    logic [3:0]        f1;
    logic [3:0]        f2;
    logic [3:0]        f3;

    assign opcode = ir[15:12];
    assign f1     = ir[11:8];
    assign f2     = ir[7:4];
    assign f3     = ir[3:0];
    assign imm_z  = DATA_W'(f3);

    // Reset leaves the FSM in FETCH; gating with rst_n keeps the request low while held.
    assign imem_req  = rst_n && (state == StFetch);
    assign imem_addr = pc;
    assign dmem_req  = (state == StMem);
    assign halted    = (state == StHalt);

    always_comb begin
        alu = '0;
        case (opcode)
            OpAdd:              alu = op_a + op_b;
            OpSub:              alu = op_a - op_b;
            OpAnd:              alu = op_a & op_b;
            OpOr:               alu = op_a | op_b;
            OpSlt:              alu = ($signed(op_a) < $signed(op_b)) ? DATA_W'(1) : '0;
            OpAddi, OpLw, OpSw: alu = op_a + imm_z;
            default:            alu = '0;
        endcase
    end

    // Stores retire in the ack cycle itself, so retire cannot be a registered flag.
    always_comb begin
        retire = 1'b0;
        case (state)
            StExec:  retire = (opcode >= OpBeq);
            StMem:   retire = dmem_ack && dmem_we;
            StWb:    retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StFetch;
            pc         <= '0;
            ir         <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_d       <= '0;
            result     <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                StFetch: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        pc    <= pc + PC_W'(1);
                        state <= StDecode;
                    end
                end
                StDecode: begin
                    op_a  <= regs[f2];
                    op_b  <= regs[f3];
                    op_d  <= regs[f1];
                    state <= StExec;
                end
                StExec: begin
                    result <= alu;
                    if (opcode == OpLw || opcode == OpSw) begin
                        dmem_we    <= (opcode == OpSw);
                        dmem_addr  <= DADDR_W'(alu);
                        dmem_wdata <= op_d;
                        state      <= StMem;
                    end else if (opcode <= OpAddi) begin
                        state <= StWb;
                    end else if (opcode == OpHalt) begin
                        state <= StHalt;
                    end else begin
                        // pc already points past the branch; the offset is sign-extended.
                        if (opcode == OpBeq && op_d == op_a) begin
                            pc <= pc + PC_W'($signed(f3));
                        end else if (opcode == OpJmp) begin
                            pc <= PC_W'(ir[11:0]);
                        end
                        state <= StFetch;
                    end
                end
                StMem: begin
                    if (dmem_ack) begin
                        dmem_we <= 1'b0;
                        if (dmem_we) begin
                            state <= StFetch;
                        end else begin
                            result <= dmem_rdata;
                            state  <= StWb;
                        end
                    end
                end
                StWb: begin
                    if (f1 != 4'd0) begin
                        regs[f1] <= result;
                    end
                    state <= StFetch;
                end
                StHalt: begin
                    state <= StHalt;
                end
                default: begin
                    state <= StFetch;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: directed programs plus random programs checked against an
// instruction-level model with wait-state-aware cycle accounting.
module tb_cpu_multicycle;

    localparam int DW = 16;
    localparam int PW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_ack;
    logic [15:0]   imem_rdata;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;
    logic [PW-1:0] pc;
    logic          retire;
    logic          halted;

    always #5 clk = ~clk;

    cpu_multicycle #(.DATA_W(DW), .PC_W(PW), .DADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .pc         (pc),
        .retire     (retire),
        .halted     (halted)
    );

    // Memory models with a fixed number of wait cycles per access.
    logic [15:0] imem      [256];
    logic [DW-1:0] dmem    [256];
    logic [DW-1:0] dmem_init [256];
    logic load_dmem = 1'b0;
    int iwait = 0;
    int dwait = 0;
    int icnt = 0;
    int dcnt = 0;

    assign imem_ack   = imem_req && (icnt == iwait);
    assign imem_rdata = imem[imem_addr];
    assign dmem_ack   = dmem_req && (dcnt == dwait);
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk) begin
        icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
        dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
        if (load_dmem) begin
            for (int i = 0; i < 256; i++) dmem[i] <= dmem_init[i];
        end else if (dmem_req && dmem_ack && dmem_we) begin
            dmem[dmem_addr] <= dmem_wdata;
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state
    logic [15:0] m_regs [16];
    logic [15:0] m_mem  [256];
    int          m_ret[$];
    int          m_pc;

    // Observations from a run
    int            ret_cyc[$];
    int            fetch_addrs[$];
    int            both_req_cnt;
    int            unstable_cnt;
    int            dreq_cnt;
    bit            sw_seen;
    logic [AW-1:0] sw_addr;
    logic [DW-1:0] sw_wdata;

    function automatic bit same_q(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        for (int i = 0; i < a.size(); i++) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int reg_mismatches();
        int n = 0;
        for (int i = 0; i < 16; i++) if (dut.regs[i] !== m_regs[i]) n++;
        return n;
    endfunction

    function automatic int mem_mismatches();
        int n = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== m_mem[i]) n++;
        return n;
    endfunction

    task automatic prep_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            imem[i]      = 16'hF000;
            dmem_init[i] = 16'($urandom);
            m_mem[i]     = dmem_init[i];
        end
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        load_dmem = 1'b1;
        @(posedge clk);
        #1 load_dmem = 1'b0;
        @(posedge clk);
    endtask

    // Instruction-level model: register/memory effects plus the cycle each instruction retires.
    task automatic model_run(input int iw, input int dw);
        int cyc, p, op, rd, rs, rt, off, addr;
        logic [15:0] ins, a, b, d, val;
        bit wb, done;
        cyc = 0;
        p = 0;
        done = 1'b0;
        m_ret.delete();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        for (int n = 0; n < 500 && !done; n++) begin
            ins = imem[p];
            p = (p + 1) % 256;
            op = int'(ins[15:12]);
            rd = int'(ins[11:8]);
            rs = int'(ins[7:4]);
            rt = int'(ins[3:0]);
            a = m_regs[rs];
            b = m_regs[rt];
            d = m_regs[rd];
            addr = (int'(a) + rt) % 256;
            wb = 1'b0;
            val = '0;
            cyc += 3 + iw;
            case (op)
                0: val = a + b;
                1: val = a - b;
                2: val = a & b;
                3: val = a | b;
                4: val = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
                5: val = a + 16'(rt);
                6: begin val = m_mem[addr]; wb = 1'b1; cyc += 2 + dw; end
                7: begin m_mem[addr] = d; cyc += 1 + dw; end
                8: if (d == a) begin
                    off = (rt >= 8) ? rt - 16 : rt;
                    p = (p + off + 256) % 256;
                end
                9: p = int'(ins[11:0]) % 256;
                15: done = 1'b1;
                default: ;
            endcase
            if (op <= 5) begin
                wb = 1'b1;
                cyc += 1;
            end
            if (wb && rd != 0) m_regs[rd] = val;
            m_ret.push_back(cyc);
        end
        m_pc = p;
    endtask

    task automatic run_prog(input int iw, input int dw, input int budget);
        int cyc;
        logic was_wait;
        logic [PW-1:0] last_addr;
        ret_cyc.delete();
        fetch_addrs.delete();
        both_req_cnt = 0;
        unstable_cnt = 0;
        dreq_cnt = 0;
        sw_seen = 1'b0;
        sw_addr = '0;
        sw_wdata = '0;
        iwait = iw;
        dwait = dw;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cyc = 1;
        was_wait = 1'b0;
        last_addr = '0;
        while (cyc <= budget && halted !== 1'b1) begin
            if (retire) ret_cyc.push_back(cyc);
            if (imem_req && imem_ack) fetch_addrs.push_back(int'(imem_addr));
            if (imem_req && dmem_req) both_req_cnt++;
            if (dmem_req) dreq_cnt++;
            if (dmem_req && dmem_we && !sw_seen) begin
                sw_seen = 1'b1;
                sw_addr = dmem_addr;
                sw_wdata = dmem_wdata;
            end
            if (was_wait && (imem_req !== 1'b1 || imem_addr !== last_addr)) unstable_cnt++;
            was_wait = imem_req && !imem_ack;
            last_addr = imem_addr;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        prep_reset();
        #1;
        n_checks++;
        if ({imem_req, dmem_req, dmem_we, retire, halted} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {imem_req, dmem_req, dmem_we, retire, halted});
        end
        n_checks++;
        if (pc !== 8'd0 || imem_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_pc got pc=%0d addr=%0d want 0", pc, imem_addr);
        end
        n_checks++;
        if (dmem_addr !== 8'd0 || dmem_wdata !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_daddr got %0h/%0h want 0/0", dmem_addr, dmem_wdata);
        end
        n_checks++;
        if (reg_mismatches() != 0) begin
            n_fail++;
            $display("FAIL reset_regs got %0d nonzero want 0", reg_mismatches());
        end
    endtask

    task automatic load_arith();
        imem[0] = 16'h5105;  // ADDI r1,r0,5
        imem[1] = 16'h5203;  // ADDI r2,r0,3
        imem[2] = 16'h1312;  // SUB  r3,r1,r2
        imem[3] = 16'h4421;  // SLT  r4,r2,r1
        imem[4] = 16'hF000;  // HALT
    endtask

    task automatic test_zero_wait();
        int exp_ret[$];
        exp_ret = '{4, 8, 12, 16, 19};
        prep_reset();
        load_arith();
        run_prog(0, 0, 200);
        n_checks++;
        if (dut.regs[3] !== 16'd2 || dut.regs[4] !== 16'd1) begin
            n_fail++;
            $display("FAIL zw_regs got r3=%0d r4=%0d want 2 1", dut.regs[3], dut.regs[4]);
        end
        n_checks++;
        if (!same_q(ret_cyc, exp_ret)) begin
            n_fail++;
            $display("FAIL zw_retire got %p want %p", ret_cyc, exp_ret);
        end
        n_checks++;
        if (halted !== 1'b1 || pc !== 8'd5) begin
            n_fail++;
            $display("FAIL zw_halt got halted=%b pc=%0d want 1 5", halted, pc);
        end
        repeat (6) @(negedge clk);
        n_checks++;
        if (halted !== 1'b1 || pc !== 8'd5 || imem_req !== 1'b0 || dmem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL zw_hold got halted=%b pc=%0d ireq=%b dreq=%b want 1 5 0 0",
                     halted, pc, imem_req, dmem_req);
        end
    endtask

    task automatic test_wait_states();
        int exp_ret[$];
        exp_ret = '{7, 14, 21, 28, 34};
        prep_reset();
        load_arith();
        run_prog(3, 0, 300);
        n_checks++;
        if (dut.regs[3] !== 16'd2 || dut.regs[4] !== 16'd1) begin
            n_fail++;
            $display("FAIL ws_regs got r3=%0d r4=%0d want 2 1", dut.regs[3], dut.regs[4]);
        end
        n_checks++;
        if (!same_q(ret_cyc, exp_ret)) begin
            n_fail++;
            $display("FAIL ws_retire got %p want %p", ret_cyc, exp_ret);
        end
        n_checks++;
        if (unstable_cnt != 0) begin
            n_fail++;
            $display("FAIL ws_req_stable got %0d glitches want 0", unstable_cnt);
        end
        n_checks++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL ws_halt got %b want 1", halted);
        end
    endtask

    task automatic test_mem_round_trip();
        int exp_ret[$];
        exp_ret = '{4, 10, 17, 20};
        prep_reset();
        imem[0] = 16'h5107;  // ADDI r1,r0,7
        imem[1] = 16'h7102;  // SW   r1,2(r0)
        imem[2] = 16'h6502;  // LW   r5,2(r0)
        run_prog(0, 2, 300);
        n_checks++;
        if (!sw_seen || sw_addr !== 8'd2 || sw_wdata !== 16'd7) begin
            n_fail++;
            $display("FAIL mem_sw_req got seen=%b addr=%0d wdata=%0d want 1 2 7",
                     sw_seen, sw_addr, sw_wdata);
        end
        n_checks++;
        if (dut.regs[5] !== 16'd7 || dmem[2] !== 16'd7) begin
            n_fail++;
            $display("FAIL mem_data got r5=%0d M2=%0d want 7 7", dut.regs[5], dmem[2]);
        end
        n_checks++;
        if (both_req_cnt != 0) begin
            n_fail++;
            $display("FAIL mem_req_overlap got %0d want 0", both_req_cnt);
        end
        n_checks++;
        if (!same_q(ret_cyc, exp_ret)) begin
            n_fail++;
            $display("FAIL mem_retire got %p want %p", ret_cyc, exp_ret);
        end
    endtask

    task automatic test_branch_jump_r0();
        int exp_fetch[$];
        int exp_ret[$];
        exp_fetch = '{0, 255, 163, 164};
        exp_ret = '{3, 6, 10, 13};
        prep_reset();
        imem[0]   = 16'h800E;  // BEQ r0,r0,-2
        imem[255] = 16'h90A3;  // JMP 0x0A3
        imem[163] = 16'h5009;  // ADDI r0,r0,9
        run_prog(0, 0, 200);
        n_checks++;
        if (!same_q(fetch_addrs, exp_fetch)) begin
            n_fail++;
            $display("FAIL br_fetch_addrs got %p want %p", fetch_addrs, exp_fetch);
        end
        n_checks++;
        if (dut.regs[0] !== 16'd0) begin
            n_fail++;
            $display("FAIL br_r0 got %0d want 0", dut.regs[0]);
        end
        n_checks++;
        if (!same_q(ret_cyc, exp_ret)) begin
            n_fail++;
            $display("FAIL br_retire got %p want %p", ret_cyc, exp_ret);
        end
        n_checks++;
        if (pc !== 8'd165) begin
            n_fail++;
            $display("FAIL br_pc got %0d want 165", pc);
        end
    endtask

    task automatic test_reset_mid_mem();
        bit seen;
        prep_reset();
        imem[0] = 16'h5107;  // ADDI r1,r0,7
        imem[1] = 16'h5201;  // ADDI r2,r0,1
        imem[2] = 16'h7120;  // SW   r1,0(r2)
        iwait = 0;
        dwait = 1000;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (dmem_req === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rm_dreq_timeout got dmem_req=%b want 1 within 40 cycles", dmem_req);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dmem_req !== 1'b0 || imem_req !== 1'b0 || dmem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_req_drop got dreq=%b ireq=%b we=%b want 0 0 0",
                     dmem_req, imem_req, dmem_we);
        end
        n_checks++;
        if (pc !== 8'd0 || reg_mismatches() != 0) begin
            n_fail++;
            $display("FAIL rm_state got pc=%0d nonzero_regs=%0d want 0 0", pc, reg_mismatches());
        end
        repeat (2) @(posedge clk);
        n_checks++;
        if (mem_mismatches() != 0) begin
            n_fail++;
            $display("FAIL rm_mem_untouched got %0d changed words want 0", mem_mismatches());
        end
        run_prog(0, 0, 200);
        n_checks++;
        if (fetch_addrs.size() == 0 || fetch_addrs[0] != 0) begin
            n_fail++;
            $display("FAIL rm_first_fetch got %p want first 0", fetch_addrs);
        end
        n_checks++;
        if (dmem[1] !== 16'd7) begin
            n_fail++;
            $display("FAIL rm_rerun_store got %0d want 7", dmem[1]);
        end
    endtask

    task automatic test_nop();
        int exp_ret[$];
        exp_ret = '{3, 6};
        prep_reset();
        imem[0] = 16'hB123;
        run_prog(0, 0, 100);
        n_checks++;
        if (!same_q(ret_cyc, exp_ret)) begin
            n_fail++;
            $display("FAIL nop_retire got %p want %p", ret_cyc, exp_ret);
        end
        n_checks++;
        if (reg_mismatches() != 0 || dreq_cnt != 0) begin
            n_fail++;
            $display("FAIL nop_side_effects got regs=%0d dreq=%0d want 0 0",
                     reg_mismatches(), dreq_cnt);
        end
        n_checks++;
        if (mem_mismatches() != 0 || pc !== 8'd2) begin
            n_fail++;
            $display("FAIL nop_mem_pc got mem=%0d pc=%0d want 0 2", mem_mismatches(), pc);
        end
    endtask

    task automatic test_random();
        int op_tab[12];
        int iw, dw;
        logic [15:0] ins;
        op_tab = '{0, 1, 2, 3, 4, 5, 5, 5, 6, 7, 8, 11};
        for (int it = 0; it < 20; it++) begin
            prep_reset();
            for (int k = 0; k < 12; k++) begin
                ins = 16'($urandom);
                ins[15:12] = 4'(op_tab[$urandom_range(0, 11)]);
                if (ins[15:12] == 4'h8) ins[3] = 1'b0;
                imem[k] = ins;
            end
            iw = $urandom_range(0, 2);
            dw = $urandom_range(0, 2);
            model_run(iw, dw);
            run_prog(iw, dw, 2000);
            n_checks++;
            if (halted !== 1'b1 || pc !== PW'(m_pc)) begin
                n_fail++;
                $display("FAIL rnd%0d_halt got halted=%b pc=%0d want 1 %0d", it, halted, pc, m_pc);
            end
            n_checks++;
            if (reg_mismatches() != 0) begin
                n_fail++;
                $display("FAIL rnd%0d_regs got %0d differing regs want 0", it, reg_mismatches());
            end
            n_checks++;
            if (mem_mismatches() != 0) begin
                n_fail++;
                $display("FAIL rnd%0d_mem got %0d differing words want 0", it, mem_mismatches());
            end
            n_checks++;
            if (!same_q(ret_cyc, m_ret)) begin
                n_fail++;
                $display("FAIL rnd%0d_retire got %p want %p", it, ret_cyc, m_ret);
            end
            n_checks++;
            if (both_req_cnt != 0) begin
                n_fail++;
                $display("FAIL rnd%0d_req_overlap got %0d want 0", it, both_req_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_mem_round_trip();
        test_branch_jump_r0();
        test_reset_mid_mem();
        test_nop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
